// File: rtl/core_pkg.sv
// Shared core definitions: default datapath widths, the user-mode fetch
// window (also used by the memory checker) and the prefetch entry layout.
package core_pkg;

   localparam int CORE_DATA_W = 16;
   localparam int CORE_ADDR_W = 16;

   // Inclusive PC window legal in user mode.
   localparam logic [CORE_ADDR_W-1:0] CORE_USER_LO = 16'h4000;
   localparam logic [CORE_ADDR_W-1:0] CORE_USER_HI = 16'hBFFF;

   // One prefetch entry; the FIFO word is packed as {pc, instr} in this order.
   typedef struct packed {
      logic [CORE_ADDR_W-1:0] pc;
      logic [CORE_DATA_W-1:0] instr;
   } fifo_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered storage, flush, and a head word that is
// read straight from the storage flops (so a push is visible one cycle later).
// Head output is forced to 0 while empty.
module sync_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pop_ok;
   logic             push_ok;

   // Pointer/count update; a pop on empty is ignored, a push on full only
   // lands when a pop frees the slot in the same cycle. Flush wins.
   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      cnt_d    = cnt_q;
      pop_ok   = pop && (cnt_q != '0);
      push_ok  = push && ((cnt_q != DEPTH_C) || pop_ok);
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (push_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         end
         if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         if (push_ok && !pop_ok) begin
            cnt_d = cnt_q + CNT_W'(1);
         end else if (pop_ok && !push_ok) begin
            cnt_d = cnt_q - CNT_W'(1);
         end
      end
   end

   // Control state register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage needs no reset: the head is gated while the FIFO is empty.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign count = cnt_q;
   assign dout  = (cnt_q != '0) ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: fetch PC, prefetch FIFO of {pc, instr},
// jump redirection and user-mode fetch-range checking.
// Handshake: decode takes the head when valid_out && !stall (and no jump);
// a jump flushes everything queued in the same cycle.
module fetch_queue
   import core_pkg::*;
#(
   parameter int                DATA_W  = CORE_DATA_W,
   parameter int                ADDR_W  = CORE_ADDR_W,
   parameter int                DEPTH   = 4,
   parameter logic [ADDR_W-1:0] USER_LO = CORE_USER_LO,
   parameter logic [ADDR_W-1:0] USER_HI = CORE_USER_HI,
   parameter logic [ADDR_W-1:0] RST_PC  = '0
) (
   input  logic                    clk,
   input  logic                    rst,
   output logic [ADDR_W-1:0]       i_addr,
   input  logic                    i_hit,
   input  logic [DATA_W-1:0]       instr,
   input  logic                    jump,
   input  logic [ADDR_W-1:0]       jump_addr,
   input  logic                    mode,
   input  logic                    stall,
   output logic                    valid_out,
   output logic [DATA_W-1:0]       instr_out,
   output logic [ADDR_W-1:0]       pc_out,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    illegal_pc
);

   localparam int WIDTH = ADDR_W + DATA_W;
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic              halted_q, halted_d;
   logic              illegal_q, illegal_d;
   logic              range_ok;
   logic              pop;
   logic              push;
   logic [WIDTH-1:0]  head;
   logic [CNT_W-1:0]  fifo_cnt;

   // Handshake qualification and fetch-PC / halt next-state.
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      halted_d   = halted_q;
      illegal_d  = 1'b0;
      range_ok   = !mode || ((fetch_pc_q >= USER_LO) && (fetch_pc_q <= USER_HI));
      pop        = (fifo_cnt != '0) && !stall && !jump;
      push       = i_hit && !jump && !halted_q && range_ok &&
                   ((fifo_cnt != DEPTH_C) || pop);
      if (jump) begin
         fetch_pc_d = jump_addr;
         halted_d   = 1'b0;
      end else if (!range_ok && !halted_q) begin
         // Only reachable in user mode; the pulse fires once, then we park.
         illegal_d = 1'b1;
         halted_d  = 1'b1;
      end else if (push) begin
         fetch_pc_d = fetch_pc_q + ADDR_W'(1);
      end
   end

   // Fetch-side state register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_q <= RST_PC;
         halted_q   <= 1'b0;
         illegal_q  <= 1'b0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         halted_q   <= halted_d;
         illegal_q  <= illegal_d;
      end
   end

   sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (jump),
      .din   ({fetch_pc_q, instr}),
      .dout  (head),
      .count (fifo_cnt)
   );

   assign i_addr     = fetch_pc_q;
   assign count      = fifo_cnt;
   assign valid_out  = (fifo_cnt != '0);
   assign pc_out     = head[WIDTH-1 -: ADDR_W];
   assign instr_out  = head[DATA_W-1:0];
   assign illegal_pc = illegal_q;

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised instruction-fetch front end for the 5-stage core.
- Replaces the fixed PC register and instruction mux with a fetch PC, a DEPTH-entry prefetch FIFO of {pc, instr} pairs, and jump/flush redirection.
- Adds user-mode fetch-range checking.
- Sits between the instruction cache (i_addr/i_hit/instr) and the IF/ID boundary. Decode consumes entries through a valid/stall handshake.

Parameters:
- DATA_W, 16, instruction width.
- ADDR_W, 16, PC/address width.
- DEPTH, 4, FIFO entries; power of two, >= 2.
- USER_LO, 16'h4000, lowest PC legal in user mode.
- USER_HI, 16'hBFFF, highest PC legal in user mode.
- RST_PC, 16'h0000, fetch PC after reset.

Ports:
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- i_addr, out, ADDR_W, fetch address to I-cache; equals fetch_pc register.
- i_hit, in, 1, instr valid for i_addr this cycle.
- instr, in, DATA_W, I-cache read data.
- jump, in, 1, redirect request from decode/monitor.
- jump_addr, in, ADDR_W, redirect target.
- mode, in, 1, 1 = user mode (range check on), 0 = kernel.
- stall, in, 1, decode cannot accept this cycle.
- valid_out, out, 1, head entry is valid.
- instr_out, out, DATA_W, head instruction.
- pc_out, out, ADDR_W, head PC.
- count, out, $clog2(DEPTH)+1, occupied entries.
- illegal_pc, out, 1, one-cycle pulse: user-mode fetch attempted outside [USER_LO, USER_HI].

Behaviour:
- Reset (rst=1 at posedge):
  - fetch_pc=RST_PC, rd/wr pointers=0, count=0, halted=0.
  - valid_out=0, illegal_pc=0.
  - instr_out/pc_out=0 while empty (outputs are gated to 0 when count=0).
  - Reset mid-operation discards all entries and any pending jump.
- Push: i_hit && count<DEPTH && !jump && !halted && range_ok → write {fetch_pc, instr} at wr_ptr, fetch_pc += 1 (wraps mod 2^ADDR_W), wr_ptr++.
  - i_hit while full: data dropped, fetch_pc holds, so the same address is re-presented.
- Pop: valid_out && !stall && !jump → rd_ptr++.
  - Head is registered; an instr hit in cycle N appears at valid_out in cycle N+1 at the earliest (no bypass).
- Simultaneous push and pop with count=DEPTH: the push is accepted (count unchanged). count is updated by +push −pop.
- Jump (priority over everything except rst):
  - Clears FIFO (count=0, pointers equal), fetch_pc=jump_addr, halted=0.
  - Any same-cycle hit and pop are discarded.
  - valid_out=0 the cycle after a jump.
- Range check (mode=1 only):
  - range_ok = USER_LO <= fetch_pc <= USER_HI.
  - If !range_ok && !halted && !jump: illegal_pc=1 for exactly one cycle (registered, visible the next cycle), halted=1, no pushes.
  - While halted, i_addr holds and illegal_pc stays 0.
  - Only jump or rst clears halted. Queued entries still drain.
- mode=0: range_ok forced 1; halted is never set.
- Pointers wrap mod DEPTH. count never exceeds DEPTH or underflows. Pop while empty is ignored.

Decomposition:
- Shared package core_pkg: DATA_W/ADDR_W defaults; USER_LO/USER_HI constants (shared with the memory checker); fifo_entry_t {pc, instr}.
- One sub-module: sync_fifo (DEPTH, WIDTH, push/pop/flush, count, registered head) instantiated with WIDTH=ADDR_W+DATA_W.
- Fetch PC, halt logic and range check stay in fetch_queue.

Test Plan:
- Reset, then i_hit=1 every cycle, stall=0, instr=16'hA000+addr: valid_out rises one cycle after the first hit; pc_out sequence 0,1,2…; instr_out 16'hA000,16'hA001…; count stays at 1.
- stall=1 with continuous hits, DEPTH=4: count reaches 4 after 4 hits; i_addr holds at 4; dropping stall pops pc 0 next cycle and accepts addr 4 in the same cycle (count stays 4).
- Queue holding 3 entries, jump=1, jump_addr=16'h0100 with a simultaneous hit: next cycle count=0, valid_out=0, i_addr=16'h0100; the next head is pc 16'h0100.
- mode=1, jump to 16'h3FFF: one-cycle illegal_pc pulse, no push, i_addr frozen at 16'h3FFF; jump to 16'h4000 resumes fetch. With mode=0, fetch at 16'h3FFF is accepted.
- fetch_pc=16'hFFFF, mode=0, hit: entry pc 16'hFFFF pushed; i_addr wraps to 16'h0000.
- rst asserted with count=3 and halted=1: next cycle count=0, valid_out=0, illegal_pc=0, i_addr=RST_PC.
